// File: rtl/pivot_processor_pkg.sv
// Shared row-operation encoding used by the pivot cell and the processor_B row cells.
package pivot_processor_pkg;

   localparam int unsigned OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_PASS = 2'b00,
      OP_ADD  = 2'b01,
      OP_SWAP = 2'b10
   } op_e;

endpackage

// File: rtl/pivot_processor.sv
// Pivot cell of a GF(2) systolic eliminator: picks the first row with a set diagonal bit
// as pivot and broadcasts swap/add/pass operations to the processor_B cells of each row.
module pivot_processor
   import pivot_processor_pkg::*;
#(
   parameter int unsigned N_ROWS = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       valid_in,
   input  logic                       data_in,
   output logic [OP_W-1:0]            op_out,
   output logic                       valid_out,
   output logic                       data_out,
   output logic [$clog2(N_ROWS)-1:0]  pivot_row,
   output logic                       done,
   output logic                       fail
);

   localparam int unsigned CNT_W = $clog2(N_ROWS);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SEARCH = 2'b01,
      FINISH = 2'b10
   } state_e;

   state_e             state, state_nxt;
   logic               r, r_nxt;
   logic [CNT_W-1:0]   row_cnt, row_cnt_nxt;
   logic [CNT_W-1:0]   pivot_nxt;
   logic               fail_nxt, done_nxt, data_nxt;
   op_e                op_nxt;
   logic               accept, last_row;

   // A row counts only while searching; a start in the same cycle discards it.
   assign accept   = (state == SEARCH) && valid_in && !start;
   assign last_row = (row_cnt == CNT_W'(N_ROWS - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; start wins over every transition, including FINISH -> IDLE
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = SEARCH;
      end else begin
         case (state)
            IDLE:    state_nxt = IDLE;
            SEARCH:  if (accept && last_row) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Output/datapath next values
   always_comb begin
      r_nxt       = r;
      row_cnt_nxt = row_cnt;
      pivot_nxt   = pivot_row;
      fail_nxt    = fail;
      done_nxt    = 1'b0;
      op_nxt      = OP_PASS;
      if (start) begin
         r_nxt       = 1'b0;
         row_cnt_nxt = '0;
         pivot_nxt   = '0;
         fail_nxt    = 1'b0;
      end else if (accept) begin
         if (data_in && !r) begin
            op_nxt    = OP_SWAP;
            r_nxt     = 1'b1;
            pivot_nxt = row_cnt;
         end else if (data_in) begin
            op_nxt = OP_ADD;
         end
         if (last_row) begin
            row_cnt_nxt = '0;
            done_nxt    = 1'b1;
            // fail reflects the pivot state including the row accepted this cycle
            fail_nxt    = ~(r | data_in);
         end else begin
            row_cnt_nxt = row_cnt + CNT_W'(1);
         end
      end
      data_nxt = (op_nxt == OP_PASS) ? data_in : 1'b0;
   end

   // Registered outputs and pass state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r         <= 1'b0;
         row_cnt   <= '0;
         op_out    <= OP_PASS;
         valid_out <= 1'b0;
         data_out  <= 1'b0;
         pivot_row <= '0;
         done      <= 1'b0;
         fail      <= 1'b0;
      end else begin
         r         <= r_nxt;
         row_cnt   <= row_cnt_nxt;
         op_out    <= op_nxt;
         valid_out <= valid_in;
         data_out  <= data_nxt;
         pivot_row <= pivot_nxt;
         done      <= done_nxt;
         fail      <= fail_nxt;
      end
   end

endmodule

// File: tb/tb_pivot_processor.sv
// Scoreboard bench for pivot_processor with N_ROWS=4: a reference pivot model pushes
// expected row operations as rows are driven; they are popped when valid_out appears.
module tb_pivot_processor;
   import pivot_processor_pkg::*;

   localparam int unsigned N_ROWS = 4;
   localparam int unsigned CNT_W  = $clog2(N_ROWS);

   logic             clk = 1'b0;
   logic             rst;
   logic             start, valid_in, data_in;
   logic [1:0]       op_out;
   logic             valid_out, data_out, done, fail;
   logic [CNT_W-1:0] pivot_row;

   pivot_processor #(.N_ROWS(N_ROWS)) dut (
      .clk(clk), .rst(rst), .start(start), .valid_in(valid_in), .data_in(data_in),
      .op_out(op_out), .valid_out(valid_out), .data_out(data_out),
      .pivot_row(pivot_row), .done(done), .fail(fail)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] op;
      logic       data;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   // reference model state
   logic             m_act, m_r, m_fail;
   logic [CNT_W-1:0] m_piv;
   int               m_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_act = 1'b0; m_r = 1'b0; m_fail = 1'b0; m_piv = '0; m_cnt = 0;
   endtask

   // one clock: drive inputs, update the model, then check every output after the edge
   task automatic cycle(input logic s, input logic v, input logic d);
      exp_t e;
      logic e_done;
      start = s; valid_in = v; data_in = d;
      e.op = 2'(OP_PASS);
      e_done = 1'b0;
      if (s) begin
         m_act = 1'b1; m_r = 1'b0; m_fail = 1'b0; m_piv = '0; m_cnt = 0;
      end else if (m_act && v) begin
         if (d && !m_r) begin
            e.op = 2'(OP_SWAP); m_r = 1'b1; m_piv = CNT_W'(m_cnt);
         end else if (d) begin
            e.op = 2'(OP_ADD);
         end
         if (m_cnt == N_ROWS - 1) begin
            m_act = 1'b0; e_done = 1'b1; m_fail = !m_r; m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end
      e.data = (e.op == 2'(OP_PASS)) ? d : 1'b0;
      if (v) sbq.push_back(e);
      @(posedge clk);
      #1;
      check_eq("valid_out", 32'(valid_out), 32'(v));
      if (valid_out) begin
         if (sbq.size() == 0) begin
            check_eq("sb_empty", 32'(1), 32'(0));
         end else begin
            e = sbq.pop_front();
            check_eq("op_out", 32'(op_out), 32'(e.op));
            check_eq("data_out", 32'(data_out), 32'(e.data));
         end
      end
      check_eq("done", 32'(done), 32'(e_done));
      check_eq("fail", 32'(fail), 32'(m_fail));
      check_eq("pivot_row", 32'(pivot_row), 32'(m_piv));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_op"}, 32'(op_out), 32'(OP_PASS));
      check_eq({tag, "_valid"}, 32'(valid_out), 32'(0));
      check_eq({tag, "_data"}, 32'(data_out), 32'(0));
      check_eq({tag, "_pivot"}, 32'(pivot_row), 32'(0));
      check_eq({tag, "_done"}, 32'(done), 32'(0));
      check_eq({tag, "_fail"}, 32'(fail), 32'(0));
   endtask

   task automatic pass4(input logic [3:0] rows);
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, rows[i]);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; valid_in = 1'b0; data_in = 1'b0;
      model_clear();
      #1;
      check_reset_outputs("por");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // rows 0,1,1,0 -> PASS,SWAP,ADD,PASS, pivot 1
      pass4(4'b0110);
      check_eq("p1_pivot", 32'(pivot_row), 32'(1));
      check_eq("p1_fail", 32'(fail), 32'(0));
      cycle(1'b0, 1'b0, 1'b0);
      check_eq("p1_hold_pivot", 32'(pivot_row), 32'(1));

      // all-zero column -> fail
      pass4(4'b0000);
      check_eq("p2_fail", 32'(fail), 32'(1));
      check_eq("p2_pivot", 32'(pivot_row), 32'(0));
      cycle(1'b0, 1'b0, 1'b0);
      check_eq("p2_fail_sticky", 32'(fail), 32'(1));

      // rows 1,0,gap,1,1 -> SWAP,PASS,(stall),ADD,ADD
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1);
      check_eq("p3_no_early_done", 32'(done), 32'(0));
      cycle(1'b0, 1'b1, 1'b1);
      check_eq("p3_done", 32'(done), 32'(1));

      // reset after two rows aborts the pass
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b1);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      sbq.delete();
      model_clear();
      valid_in = 1'b0; start = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rst_no_done", 32'(done), 32'(0));
      rst = 1'b0;
      pass4(4'b0100);
      check_eq("p4_pivot", 32'(pivot_row), 32'(2));

      // start with valid_in: row discarded, counter still at 0
      cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b0);
      check_eq("p5_no_early_done", 32'(done), 32'(0));
      cycle(1'b0, 1'b1, 1'b0);
      check_eq("p5_done", 32'(done), 32'(1));

      // start arriving during FINISH opens the next pass
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0);
      check_eq("p6_fail", 32'(fail), 32'(1));

      // random passes with random gaps
      for (int p = 0; p < 20; p++) begin
         cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         for (int k = 0; k < 12; k++)
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pivot_processor.md
PIVOT_PROCESSOR -- requirements
Module: pivot_processor

Interface
REQ-001 SHALL have parameter N_ROWS, default 8, meaning rows streamed through the cell per elimination pass (>=2).
REQ-002 SHALL have derived localparam CNT_W = clog2(N_ROWS), meaning width of row counter and pivot index.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse opening a new pass.
REQ-006 SHALL have port valid_in  input  1  data_in carries a row bit this cycle.
REQ-007 SHALL have port data_in  input  1  diagonal bit of the current row.
REQ-008 SHALL have port op_out  output  2  operation broadcast to the row of processor_B cells.
REQ-009 SHALL have port valid_out  output  1  op_out/data_out qualify a row.
REQ-010 SHALL have port data_out  output  1  eliminated diagonal bit to the next stage.
REQ-011 SHALL have port pivot_row  output  CNT_W  index of the row taken as pivot.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of pass.
REQ-013 SHALL have port fail  output  1  sticky, pass ended with no pivot.

Function
REQ-014 SHALL use op encoding OP_PASS=2'b00, OP_ADD=2'b01, OP_SWAP=2'b10; 2'b11 never driven.
REQ-015 SHALL implement FSM IDLE -> SEARCH on start; SEARCH -> FINISH on accepted row with row_cnt==N_ROWS-1; FINISH -> IDLE unconditionally next cycle.
REQ-016 SHALL, on start (any state), clear pivot register r, row_cnt, fail, pivot_row and enter SEARCH; a valid_in coincident with start is discarded.
REQ-017 SHALL, in SEARCH per accepted row: r==0 & data_in==1 -> SWAP, r<=1, pivot_row<=row_cnt; r==1 & data_in==1 -> ADD; otherwise PASS.
REQ-018 SHALL increment row_cnt only on accepted rows (valid_in high in SEARCH, no start); gaps in valid_in stall the pass.
REQ-019 SHALL register op_out, valid_out, data_out: latency exactly 1 cycle from valid_in.
REQ-020 SHALL drive data_out = 0 for SWAP and ADD, data_in for PASS.
REQ-021 SHALL drive valid_out = registered valid_in in all states; op_out = OP_PASS outside SEARCH.
REQ-022 SHALL assert done for exactly one cycle in FINISH, coincident with fail update (fail <= ~r).
REQ-023 SHALL hold fail and pivot_row stable from FINISH until the next start.
REQ-024 SHALL ignore start in FINISH? No: start in FINISH takes precedence over the FINISH -> IDLE transition and enters SEARCH; done still pulses.

Reset
REQ-025 SHALL, on rst, asynchronously force state=IDLE, r=0, row_cnt=0, op_out=OP_PASS, valid_out=0, data_out=0, pivot_row=0, done=0, fail=0.
REQ-026 SHALL abort a pass when rst is asserted mid-pass; no done pulse is produced for it.
REQ-027 SHALL accept start on the first rising edge after rst deasserts.

Structure
REQ-028 SHALL take OP_PASS/OP_ADD/OP_SWAP from the shared systemizer define/package also used by processor_B; FSM state encoding stays local.
REQ-029 SHALL be a single flat module; no sub-module.

Verification (N_ROWS=4)
REQ-030 SHALL cover: start, rows 0,1,1,0 -> op_out PASS,SWAP,ADD,PASS one cycle later, pivot_row=1, done pulse, fail=0.
REQ-031 SHALL cover: start, rows 0,0,0,0 -> all PASS, done pulse, fail=1, pivot_row=0.
REQ-032 SHALL cover: rows 1,x,gap,1,1 with valid_in low in gap -> row_cnt stalls, ops SWAP,ADD,ADD, done after 4th accepted row.
REQ-033 SHALL cover: rst asserted after 2 rows -> all outputs reset immediately, no done; fresh pass afterwards correct.
REQ-034 SHALL cover: start coincident with valid_in=1 -> that bit discarded, valid_out=1 with op_out=OP_PASS, row_cnt stays 0.
